// File: rtl/wave_scaler_if.sv
// Sample stream bundle for wave_scaler: input and output valid/ready handshakes
// plus the saturation flag that travels with each output sample.
interface wave_scaler_if #(
  parameter int unsigned DATA_NBIT = 20
);
  logic                 in_dv;
  logic [DATA_NBIT-1:0] in_data;
  logic                 in_ready;
  logic                 out_dv;
  logic [DATA_NBIT-1:0] out_data;
  logic                 out_sat;
  logic                 out_ready;

  modport slave (
    input  in_dv, in_data, out_ready,
    output in_ready, out_dv, out_data, out_sat
  );

  modport master (
    output in_dv, in_data, out_ready,
    input  in_ready, out_dv, out_data, out_sat
  );
endinterface

// File: rtl/wave_scaler.sv
// Two-stage gain/offset scaler with saturation, valid/ready backpressure and
// synchronised gain switches. Define WAVE_SCALER_RAMP_EN to ramp gain changes.
module wave_scaler #(
  parameter int unsigned DATA_NBIT = 20,
  parameter int unsigned GAIN_NBIT = 16,
  parameter int unsigned RAMP_STEP = 32'h1000
) (
  input  logic                 mclk,
  input  logic                 rst_n,
  input  logic [2:0]           wave_sel,
  input  logic [2:0]           wave_gain,
  input  logic [DATA_NBIT-1:0] offset,
  wave_scaler_if.slave         bus,
  output logic [GAIN_NBIT:0]   cur_gain
);
  localparam int unsigned GW = GAIN_NBIT + 1;
  localparam int unsigned PW = DATA_NBIT + GAIN_NBIT + 1;
  localparam int unsigned TW = DATA_NBIT + 2;

  localparam logic [GW-1:0]        UNITY = GW'(longint'(1) << (GAIN_NBIT - 1));
  localparam logic signed [PW-1:0] RND   = PW'(longint'(1) <<< (GAIN_NBIT - 2));
  localparam logic signed [TW-1:0] MAX_T = TW'((longint'(1) <<< (DATA_NBIT - 1)) - 1);
  localparam logic signed [TW-1:0] MIN_T = TW'(-(longint'(1) <<< (DATA_NBIT - 1)));

  if (RAMP_STEP == 0 || RAMP_STEP >= (32'd1 << GAIN_NBIT)) begin : g_bad_step
    $error("wave_scaler: RAMP_STEP out of range");
  end

  // Gain table entries are given as Q1.15; rescale to the configured fraction width.
  function automatic logic [GW-1:0] q15(input logic [15:0] v);
    return GW'((64'(v) << GAIN_NBIT) >> 16);
  endfunction

  logic [2:0]    sel_m, sel_s, gsel_m, gsel_s;
  logic [GW-1:0] target, lut_c, gain_nxt_c;

  // Two-flop synchronisers for the asynchronous switches
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sel_m  <= '0;
      sel_s  <= '0;
      gsel_m <= '0;
      gsel_s <= '0;
    end else begin
      sel_m  <= wave_sel;
      sel_s  <= sel_m;
      gsel_m <= wave_gain;
      gsel_s <= gsel_m;
    end
  end

  always_comb begin
    lut_c = q15(16'h8000);
    case ({sel_s, gsel_s})
      6'b001_001: lut_c = q15(16'h8000);
      6'b010_001: lut_c = q15(16'h6666);
      6'b010_010: lut_c = q15(16'h3333);
      6'b100_001: lut_c = q15(16'h6666);
      6'b100_010: lut_c = q15(16'h6000);
      6'b100_100: lut_c = q15(16'h3333);
      default:    lut_c = q15(16'h8000);
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) target <= UNITY;
    else        target <= lut_c;
  end

  // Pipeline handshake
  logic v1, v2, adv1, adv2, accept;

  assign adv2         = !v2 || bus.out_ready;
  assign adv1         = !v1 || adv2;
  assign accept       = bus.in_dv && adv1;
  assign bus.in_ready = adv1;

`ifdef WAVE_SCALER_RAMP_EN
  localparam logic [GW-1:0] STEP = GW'(RAMP_STEP);

  // Gain only moves when a sample is accepted, at most STEP per sample
  always_comb begin
    gain_nxt_c = cur_gain;
    if (accept) begin
      if (cur_gain < target)
        gain_nxt_c = (target - cur_gain > STEP) ? cur_gain + STEP : target;
      else if (cur_gain > target)
        gain_nxt_c = (cur_gain - target > STEP) ? cur_gain - STEP : target;
    end
  end
`else
  assign gain_nxt_c = target;
`endif

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) cur_gain <= UNITY;
    else        cur_gain <= gain_nxt_c;
  end

  // Stage 1: multiply by the gain in force before this edge's update
  logic signed [PW-1:0]        prod_c, p1;
  logic signed [DATA_NBIT-1:0] off1;

  assign prod_c = PW'(signed'(bus.in_data)) * PW'(signed'(cur_gain));

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      p1   <= '0;
      off1 <= '0;
    end else if (adv1) begin
      v1 <= bus.in_dv;
      if (accept) begin
        p1   <= prod_c;
        off1 <= signed'(offset);
      end
    end
  end

  // Stage 2: round half up, add offset, clamp to the DAC code range
  logic signed [PW-1:0]  rnd_c, shr_c;
  logic signed [TW-1:0]  s_c, t_c;
  logic [DATA_NBIT-1:0]  clip_c, data2;
  logic                  sat_c, sat2;

  assign rnd_c = p1 + RND;
  assign shr_c = rnd_c >>> (GAIN_NBIT - 1);
  assign s_c   = TW'(shr_c);
  assign t_c   = s_c + TW'(off1);

  always_comb begin
    clip_c = DATA_NBIT'(t_c);
    sat_c  = 1'b0;
    if (t_c > MAX_T) begin
      clip_c = DATA_NBIT'(MAX_T);
      sat_c  = 1'b1;
    end else if (t_c < MIN_T) begin
      clip_c = DATA_NBIT'(MIN_T);
      sat_c  = 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      data2 <= '0;
      sat2  <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        data2 <= clip_c;
        sat2  <= sat_c;
      end
    end
  end

  assign bus.out_dv   = v2;
  assign bus.out_data = data2;
  assign bus.out_sat  = sat2;
endmodule

// File: tb/tb_wave_scaler.sv
// Randomised scoreboard bench for wave_scaler; expected samples come from an
// arithmetic model of gain, rounding, offset and clamping.
module tb_wave_scaler;
  localparam int unsigned DN = 20;
  localparam int unsigned GN = 16;
  localparam int          STEP = 'h1000;

  logic          mclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    wave_sel, wave_gain;
  logic [DN-1:0] offset;
  logic [GN:0]   cur_gain;

  wave_scaler_if #(.DATA_NBIT(DN)) bus ();

  wave_scaler #(.DATA_NBIT(DN), .GAIN_NBIT(GN), .RAMP_STEP(32'h1000)) dut (
    .mclk(mclk), .rst_n(rst_n), .wave_sel(wave_sel), .wave_gain(wave_gain),
    .offset(offset), .bus(bus.slave), .cur_gain(cur_gain)
  );

  always #5 mclk = ~mclk;

  typedef struct { logic [DN-1:0] d; logic s; } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;
  int n_acc = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [DN-1:0] d, input logic s);
    exp_t e;
    e.d = d;
    e.s = s;
    return e;
  endfunction

  function automatic int lut(input logic [5:0] k);
    case (k)
      6'b001001: return 'h8000;
      6'b010001: return 'h6666;
      6'b010010: return 'h3333;
      6'b100001: return 'h6666;
      6'b100010: return 'h6000;
      6'b100100: return 'h3333;
      default:   return 'h8000;
    endcase
  endfunction

  // y = clamp(floor(x*g/2^15 + 1/2) + off)
  function automatic exp_t model_out(input logic [DN-1:0] x, input int g, input logic [DN-1:0] off);
    longint xs, os, p, s, t;
    exp_t e;
    xs = longint'(signed'(x));
    os = longint'(signed'(off));
    p  = xs * longint'(g) + 64'sd16384;
    s  = (p >= 0) ? p / 32768 : -((-p + 32767) / 32768);
    t  = s + os;
    e.s = 1'b0;
    if (t > 524287)       begin t = 524287;  e.s = 1'b1; end
    else if (t < -524288) begin t = -524288; e.s = 1'b1; end
    e.d = DN'(t);
    return e;
  endfunction

  // Gain model: switch value seen at edge e reaches the target at edge e+2
  int         m_cur, m_tgt;
  logic [5:0] h1, h2;

  task automatic reset_model();
    m_cur = 'h8000;
    m_tgt = 'h8000;
    h1 = '0;
    h2 = '0;
  endtask

  task automatic model_edge(input logic acc);
    int nxt;
    nxt = lut(h2);
    h2  = h1;
    h1  = {wave_sel, wave_gain};
`ifdef WAVE_SCALER_RAMP_EN
    if (acc) begin
      if (m_cur < m_tgt)      m_cur = (m_tgt - m_cur > STEP) ? m_cur + STEP : m_tgt;
      else if (m_cur > m_tgt) m_cur = (m_cur - m_tgt > STEP) ? m_cur - STEP : m_tgt;
    end
`else
    if (acc || !acc) m_cur = m_tgt;
`endif
    m_tgt = nxt;
  endtask

  // One clock of stimulus; called in the slot just after a rising edge
  task automatic step(input logic dv, input logic [DN-1:0] d, input logic [DN-1:0] off,
                      input logic ordy, input logic use_c, input exp_t ce, output logic acc);
    exp_t e;
    bus.in_dv     = dv;
    bus.in_data   = d;
    offset        = off;
    bus.out_ready = ordy;
    @(negedge mclk);
    acc = bus.in_dv && bus.in_ready;
    chk("cur_gain", longint'(cur_gain), longint'(m_cur));
    @(posedge mclk);
    if (acc) begin
      e = use_c ? ce : model_out(d, m_cur, off);
      sbq.push_back(e);
      n_acc++;
    end
    model_edge(acc);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0, mk('0, 1'b0), a);
  endtask

  task automatic stream(input int n);
    logic a;
    for (int i = 0; i < n; i++)
      step(1'b1, DN'($urandom), DN'($urandom_range(0, 255)), 1'b1, 1'b0, mk('0, 1'b0), a);
  endtask

  task automatic set_sw(input logic [5:0] k);
    {wave_sel, wave_gain} = k;
  endtask

  // Monitor: pop on every output handshake and check hold-while-stalled
  logic          prev_stall = 1'b0;
  logic [DN-1:0] prev_d = '0;
  always @(negedge mclk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_dv", longint'(bus.out_dv), 64'd1);
        chk("hold_data", longint'(bus.out_data), longint'(prev_d));
      end
      if (bus.out_dv && bus.out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0h expected none", bus.out_data);
        end else begin
          e = sbq.pop_front();
          chk("out_data", longint'(bus.out_data), longint'(e.d));
          chk("out_sat", longint'(bus.out_sat), longint'(e.s));
        end
      end
      prev_stall = bus.out_dv && !bus.out_ready;
      prev_d     = bus.out_data;
    end
  end

  logic [5:0] keys [8] = '{6'b001001, 6'b010001, 6'b010010, 6'b100001,
                           6'b100010, 6'b100100, 6'b000000, 6'b011001};

  initial begin
    logic          a;
    int            k, cnt;
    logic [DN-1:0] dv_data, off;

    bus.in_dv = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1; offset = '0;
    set_sw(6'b001001);
    reset_model();
    repeat (2) @(posedge mclk);
    #1;
    chk("rst_out_dv", longint'(bus.out_dv), 64'd0);
    chk("rst_out_data", longint'(bus.out_data), 64'd0);
    chk("rst_out_sat", longint'(bus.out_sat), 64'd0);
    chk("rst_cur_gain", longint'(cur_gain), 64'h8000);
    chk("rst_in_ready", longint'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    reset_model();
    idle(6);

    // Unity gain and latency
    step(1'b1, 20'h40000, '0, 1'b1, 1'b1, mk(20'h40000, 1'b0), a);
    chk("unity_accept", longint'(a), 64'd1);
    chk("lat_1edge_dv", longint'(bus.out_dv), 64'd0);
    idle(1);
    chk("lat_2edge_dv", longint'(bus.out_dv), 64'd1);
    idle(2);

    // Gain 0.4 settled, then fixed vectors
    set_sw(6'b010010);
    stream(12);
    step(1'b1, 20'h40000, '0, 1'b1, 1'b1, mk(20'h19998, 1'b0), a);
    step(1'b1, 20'hC0000, '0, 1'b1, 1'b1, mk(20'hE6668, 1'b0), a);

    // Ramp up, then ramp down under a continuous stream
    set_sw(6'b001001);
    stream(12);
    set_sw(6'b010010);
    stream(14);
    set_sw(6'b001001);
    stream(12);

    // Saturation at both rails
    step(1'b1, 20'h7FFFF, 20'h00010, 1'b1, 1'b1, mk(20'h7FFFF, 1'b1), a);
    step(1'b1, 20'h80000, 20'hFFFFF, 1'b1, 1'b1, mk(20'h80000, 1'b1), a);
    idle(4);

    // Backpressure with an incrementing ramp
    k = 0;
    cnt = n_acc;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DN'(32'h100 + k), '0, 1'b0, 1'b0, mk('0, 1'b0), a);
      if (a) k++;
    end
    chk("bp_accepts", longint'(n_acc - cnt), 64'd2);
    chk("bp_in_ready", longint'(bus.in_ready), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, DN'(32'h100 + k), '0, 1'b1, 1'b0, mk('0, 1'b0), a);
      if (a) k++;
    end
    idle(4);

    // Randomised traffic, backpressure, offsets and switch changes
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) set_sw(keys[$urandom_range(0, 7)]);
      dv_data = DN'($urandom);
      off = ($urandom_range(0, 3) == 0) ? DN'($urandom) : DN'($urandom_range(0, 63));
      step(1'b1 & ($urandom_range(0, 3) != 0), dv_data, off,
           1'b1 & ($urandom_range(0, 3) != 0), 1'b0, mk('0, 1'b0), a);
    end
    idle(4);

    // Reset with both stages full
    set_sw(6'b100010);
    for (int i = 0; i < 3; i++) step(1'b1, DN'($urandom), '0, 1'b0, 1'b0, mk('0, 1'b0), a);
    chk("pre_rst_dv", longint'(bus.out_dv), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dv", longint'(bus.out_dv), 64'd0);
    chk("mid_rst_gain", longint'(cur_gain), 64'h8000);
    chk("mid_rst_in_ready", longint'(bus.in_ready), 64'd1);
    sbq.delete();
    repeat (2) @(posedge mclk);
    #1;
    rst_n = 1'b1;
    reset_model();
    for (int i = 0; i < 10; i++)
      step(1'b1, DN'($urandom), DN'($urandom_range(0, 255)),
           1'b1 & ($urandom_range(0, 2) != 0), 1'b0, mk('0, 1'b0), a);

    // Drain with a bounded wait
    for (int i = 0; i < 50 && sbq.size() != 0; i++) idle(1);
    chk("drain_empty", longint'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
